// File: rtl/cpu_boot_ctrl_if.sv
// Host command channel for cpu_boot_ctrl.
//   host_valid : command present (host -> controller)
//   host_ready : controller accepts a command this cycle (controller -> host)
//   host_cmd   : 00 WRITE, 01 RUN, 10 HALT, 11 CLEAR
//   host_addr  : WRITE address
//   host_data  : WRITE data; low CNT_W bits are the RUN cycle budget
interface cpu_boot_ctrl_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  logic              host_valid;
  logic              host_ready;
  logic [1:0]        host_cmd;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;

  modport master (output host_valid, host_cmd, host_addr, host_data, input host_ready);
  modport slave  (input host_valid, host_cmd, host_addr, host_data, output host_ready);
endinterface

// File: rtl/cpu_boot_ctrl.sv
// Boot and run sequencer: loads instruction memory from a host command
// stream, clears it, and enables the CPU for budgeted or free runs.
// Instruction memory is never written while the CPU is enabled.
//   clk, reset    : clock, asynchronous active-high reset
//   host          : command channel (slave side)
//   w_enable      : instruction memory write strobe
//   w_adrs        : write address
//   w_instruction : write data
//   cpu_en        : CPU enable
//   busy          : high while clearing or running
//   done          : one-cycle pulse on run end or clear completion
//   err           : one-cycle pulse on a command rejected during a run
module cpu_boot_ctrl #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  cpu_boot_ctrl_if.slave    host,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic [DATA_W-1:0] w_instruction,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so the sweep counter can express "all addresses written".
  localparam int unsigned CLR_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_t;
  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_HALT  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic             accept;
  cmd_t             cmd;

  assign accept = host.host_valid && host.host_ready;
  assign cmd    = cmd_t'(host.host_cmd);

  // Sequencer with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      run_cnt         <= '0;
      clr_cnt         <= '0;
      w_enable        <= 1'b0;
      w_adrs          <= '0;
      w_instruction   <= '0;
      cpu_en          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      host.host_ready <= 1'b0;
    end else begin
      w_enable <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          host.host_ready <= 1'b1;
          if (accept) begin
            case (cmd)
              CMD_WRITE: begin
                w_enable      <= 1'b1;
                w_adrs        <= host.host_addr;
                w_instruction <= host.host_data;
              end
              CMD_CLEAR: begin
                state           <= S_CLEAR;
                clr_cnt         <= '0;
                busy            <= 1'b1;
                host.host_ready <= 1'b0;
              end
              CMD_RUN: begin
                state   <= S_RUN;
                run_cnt <= host.host_data[CNT_W-1:0];
                cpu_en  <= 1'b1;
                busy    <= 1'b1;
              end
              CMD_HALT: ;
            endcase
          end
        end

        // One zero write per cycle; the cycle after the last address ends the sweep.
        S_CLEAR: begin
          if (clr_cnt[ADDR_W]) begin
            state           <= S_IDLE;
            done            <= 1'b1;
            busy            <= 1'b0;
            host.host_ready <= 1'b1;
          end else begin
            w_enable      <= 1'b1;
            w_adrs        <= clr_cnt[ADDR_W-1:0];
            w_instruction <= '0;
            clr_cnt       <= clr_cnt + CLR_W'(1);
          end
        end

        // A zero budget never decrements, so it runs until HALT without wrapping.
        S_RUN: begin
          if (accept && cmd != CMD_HALT) err <= 1'b1;
          if ((accept && cmd == CMD_HALT) || run_cnt == CNT_W'(1)) begin
            state  <= S_IDLE;
            cpu_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (run_cnt != '0) begin
            run_cnt <= run_cnt - CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed scoreboard bench for cpu_boot_ctrl (ADDR_W=4 so a clear sweep is 16 writes).
module tb_cpu_boot_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  localparam logic [1:0] C_WR   = 2'b00;
  localparam logic [1:0] C_RUN  = 2'b01;
  localparam logic [1:0] C_HALT = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adrs;
    logic [DW-1:0] instr;
    logic          cpu;
    logic          busy;
    logic          done;
    logic          err;
    logic          rdy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic          w_enable;
  logic [AW-1:0] w_adrs;
  logic [DW-1:0] w_instruction;
  logic          cpu_en, busy, done, err;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  cpu_boot_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();

  cpu_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .host          (hif),
    .w_enable      (w_enable),
    .w_adrs        (w_adrs),
    .w_instruction (w_instruction),
    .cpu_en        (cpu_en),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic c, input logic b, input logic dn, input logic e,
                              input logic r);
    exp_t x;
    x.we = we; x.adrs = we ? a : '0; x.instr = we ? d : '0;
    x.cpu = c; x.busy = b; x.done = dn; x.err = e; x.rdy = r;
    return x;
  endfunction

  // Pop the oldest expectation and compare against the current outputs.
  task automatic compare(input string tag);
    exp_t e, o;
    e = exp_q.pop_front();
    o.we = w_enable;
    o.adrs = e.we ? w_adrs : '0;
    o.instr = e.we ? w_instruction : '0;
    o.cpu = cpu_en; o.busy = busy; o.done = done; o.err = err; o.rdy = hif.host_ready;
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick_check(input exp_t e, input string tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic step(input logic v, input logic [1:0] c, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input exp_t e, input string tag);
    @(negedge clk);
    hif.host_valid = v; hif.host_cmd = c; hif.host_addr = a; hif.host_data = d;
    tick_check(e, tag);
  endtask

  initial begin
    exp_t q, r;
    q = mk(0, '0, '0, 0, 0, 0, 0, 1);   // quiet idle
    r = mk(0, '0, '0, 1, 1, 0, 0, 1);   // running

    reset = 1'b1;
    hif.host_valid = 1'b0; hif.host_cmd = C_WR; hif.host_addr = '0; hif.host_data = '0;
    @(posedge clk); #1;
    exp_q.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));
    compare("in_reset");
    @(negedge clk); reset = 1'b0;
    tick_check(q, "reset_release");

    // Back-to-back writes, one per cycle.
    step(1, C_WR, 4'd1, 32'hE000_000F, mk(1, 4'd1, 32'hE000_000F, 0, 0, 0, 0, 1), "wr0");
    step(1, C_WR, 4'd2, 32'hE005_0011, mk(1, 4'd2, 32'hE005_0011, 0, 0, 0, 0, 1), "wr1");
    step(1, C_WR, 4'd7, 32'h2000_0005, mk(1, 4'd7, 32'h2000_0005, 0, 0, 0, 0, 1), "wr2");
    step(0, C_WR, '0, '0, q, "wr_end");

    // HALT in IDLE does nothing.
    step(1, C_HALT, '0, '0, q, "halt_idle");
    step(0, C_WR, '0, '0, q, "halt_idle_after");

    // Budgeted run of 30 with a rejected WRITE at cycle 10.
    step(1, C_RUN, '0, 32'd30, r, "run30_start");
    for (int j = 1; j < 30; j++) begin
      if (j == 10) step(1, C_WR, 4'd5, 32'hDEAD_BEEF, mk(0, '0, '0, 1, 1, 0, 1, 1), "run30_err");
      else         step(0, C_WR, '0, '0, r, $sformatf("run30_c%0d", j));
    end
    step(0, C_WR, '0, '0, mk(0, '0, '0, 0, 0, 1, 0, 1), "run30_done");
    step(0, C_WR, '0, '0, q, "run30_after");

    // Free run, HALT after 100 cycles.
    step(1, C_RUN, '0, 32'd0, r, "free_start");
    for (int j = 1; j <= 100; j++) step(0, C_WR, '0, '0, r, $sformatf("free_c%0d", j));
    step(1, C_HALT, '0, '0, mk(0, '0, '0, 0, 0, 1, 0, 1), "free_halt");
    step(0, C_WR, '0, '0, q, "free_after");

    // HALT coinciding with budget expiry gives one done.
    step(1, C_RUN, '0, 32'd3, r, "run3_start");
    step(0, C_WR, '0, '0, r, "run3_c1");
    step(0, C_WR, '0, '0, r, "run3_c2");
    step(1, C_HALT, '0, '0, mk(0, '0, '0, 0, 0, 1, 0, 1), "run3_both");
    step(0, C_WR, '0, '0, q, "run3_single_done");

    // Full clear; commands offered during the sweep are not accepted.
    step(1, C_CLR, '0, '0, mk(0, '0, '0, 0, 1, 0, 0, 0), "clr_start");
    for (int k = 0; k < 16; k++)
      step(1, C_WR, 4'd9, 32'h1234_5678, mk(1, 4'(k), '0, 0, 1, 0, 0, 0), $sformatf("clr_a%0d", k));
    step(0, C_WR, '0, '0, mk(0, '0, '0, 0, 0, 1, 0, 1), "clr_done");
    step(0, C_WR, '0, '0, q, "clr_after");

    // Reset mid-clear.
    step(1, C_CLR, '0, '0, mk(0, '0, '0, 0, 1, 0, 0, 0), "rclr_start");
    for (int k = 0; k < 5; k++)
      step(0, C_WR, '0, '0, mk(1, 4'(k), '0, 0, 1, 0, 0, 0), $sformatf("rclr_a%0d", k));
    @(negedge clk); reset = 1'b1; hif.host_valid = 1'b0;
    exp_q.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));
    #1; compare("rclr_reset");
    @(negedge clk); reset = 1'b0;
    tick_check(q, "rclr_release");
    step(1, C_WR, 4'd3, 32'h0000_0055, mk(1, 4'd3, 32'h0000_0055, 0, 0, 0, 0, 1), "rclr_wr");
    step(0, C_WR, '0, '0, q, "rclr_wr_end");

    // Reset mid-run.
    step(1, C_RUN, '0, 32'd50, r, "rrun_start");
    for (int j = 1; j < 5; j++) step(0, C_WR, '0, '0, r, $sformatf("rrun_c%0d", j));
    @(negedge clk); reset = 1'b1; hif.host_valid = 1'b0;
    exp_q.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));
    #1; compare("rrun_reset");
    @(negedge clk); reset = 1'b0;
    tick_check(q, "rrun_release");
    step(1, C_WR, 4'd14, 32'hCAFE_0001, mk(1, 4'd14, 32'hCAFE_0001, 0, 0, 0, 0, 1), "rrun_wr");
    step(0, C_WR, '0, '0, q, "rrun_wr_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
